// File: rtl/tap_defs.sv
// tap_defs: TAP state encodings and instruction opcodes shared by the TAP controller files.
package tap_defs;
   typedef enum logic [3:0] {
      TLR      = 4'hF,
      RTI      = 4'hC,
      SEL_DR   = 4'h7,
      CAP_DR   = 4'h6,
      SHIFT_DR = 4'h2,
      EXIT1_DR = 4'h1,
      PAUSE_DR = 4'h3,
      EXIT2_DR = 4'h0,
      UPD_DR   = 4'h5,
      SEL_IR   = 4'h4,
      CAP_IR   = 4'hE,
      SHIFT_IR = 4'hA,
      EXIT1_IR = 4'h9,
      PAUSE_IR = 4'hB,
      EXIT2_IR = 4'h8,
      UPD_IR   = 4'hD
   } tap_state_e;
   // BYPASS is all ones at whatever IR width the controller uses
   localparam int OP_EXTEST = 0;
   localparam int OP_SAMPLE = 1;
   localparam int OP_IDCODE = 2;
endpackage

// File: rtl/tap_fsm.sv
// tap_fsm: 16-state TAP state register and TMS-driven next-state logic.
module tap_fsm
   import tap_defs::*;
(
   input  logic       clock,
   input  logic       reset_l,
   input  logic       tms,
   output tap_state_e tap_state
);
   tap_state_e state_q, state_d;
   always_ff @(posedge clock or negedge reset_l)
      if (!reset_l) state_q <= TLR;
      else state_q <= state_d;
   always_comb begin
      state_d = state_q;
      case (state_q)
         TLR:      state_d = tms ? TLR      : RTI;
         RTI:      state_d = tms ? SEL_DR   : RTI;
         SEL_DR:   state_d = tms ? SEL_IR   : CAP_DR;
         CAP_DR:   state_d = tms ? EXIT1_DR : SHIFT_DR;
         SHIFT_DR: state_d = tms ? EXIT1_DR : SHIFT_DR;
         EXIT1_DR: state_d = tms ? UPD_DR   : PAUSE_DR;
         PAUSE_DR: state_d = tms ? EXIT2_DR : PAUSE_DR;
         EXIT2_DR: state_d = tms ? UPD_DR   : SHIFT_DR;
         UPD_DR:   state_d = tms ? SEL_DR   : RTI;
         SEL_IR:   state_d = tms ? TLR      : CAP_IR;
         CAP_IR:   state_d = tms ? EXIT1_IR : SHIFT_IR;
         SHIFT_IR: state_d = tms ? EXIT1_IR : SHIFT_IR;
         EXIT1_IR: state_d = tms ? UPD_IR   : PAUSE_IR;
         PAUSE_IR: state_d = tms ? EXIT2_IR : PAUSE_IR;
         EXIT2_IR: state_d = tms ? UPD_IR   : SHIFT_IR;
         UPD_IR:   state_d = tms ? SEL_DR   : RTI;
      endcase
   end
   assign tap_state = state_q;
endmodule

// File: rtl/tap_ctrl.sv
// tap_ctrl: JTAG TAP controller with IR, bypass and ID registers,
// boundary-scan chain control decode and the TDO mux.
module tap_ctrl
   import tap_defs::*;
#(
   parameter int          IR_WIDTH   = 4,
   parameter logic [31:0] IDCODE_VAL = 32'h1876_5001
) (
   input  logic                clock,
   input  logic                reset_l,
   input  logic                tms,
   input  logic                tdi,
   input  logic                bsr_tdo,
   output logic                tdo,
   output logic                tdo_en,
   output logic                shift_dr,
   output logic                capture_dr,
   output logic                update_dr,
   output logic                test,
   output logic [IR_WIDTH-1:0] ir_out,
   output logic [3:0]          tap_state
);
   localparam logic [IR_WIDTH-1:0] IR_EXTEST  = IR_WIDTH'(OP_EXTEST);
   localparam logic [IR_WIDTH-1:0] IR_SAMPLE  = IR_WIDTH'(OP_SAMPLE);
   localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(OP_IDCODE);
   localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);
   tap_state_e          state;
   logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d, ir_q, ir_d;
   logic [31:0]         id_q, id_d;
   logic                byp_q, byp_d;
   logic                bsr_sel, id_sel;
   tap_fsm u_fsm (
      .clock     (clock),
      .reset_l   (reset_l),
      .tms       (tms),
      .tap_state (state)
   );
   always_ff @(posedge clock or negedge reset_l)
      if (!reset_l) begin
         ir_shift_q <= '0;
         ir_q       <= IR_IDCODE;
         id_q       <= '0;
         byp_q      <= 1'b0;
      end else begin
         ir_shift_q <= ir_shift_d;
         ir_q       <= ir_d;
         id_q       <= id_d;
         byp_q      <= byp_d;
      end
   // the SEL_IR/tms term restores IDCODE on the very edge that enters TLR
   always_comb begin
      ir_shift_d = state == CAP_IR ? IR_CAPTURE : state == SHIFT_IR ? {tdi, ir_shift_q[IR_WIDTH-1:1]} : ir_shift_q;
      ir_d       = (state == TLR || (state == SEL_IR && tms)) ? IR_IDCODE : state == UPD_IR ? ir_shift_q : ir_q;
      id_d       = state == CAP_DR ? (IDCODE_VAL | 32'd1) : state == SHIFT_DR ? {tdi, id_q[31:1]} : id_q;
      byp_d      = state == CAP_DR ? 1'b0 : state == SHIFT_DR ? tdi : byp_q;
   end
   assign bsr_sel    = ir_q == IR_EXTEST || ir_q == IR_SAMPLE;
   assign id_sel     = ir_q == IR_IDCODE;
   assign tdo_en     = state == SHIFT_IR || state == SHIFT_DR;
   assign tdo        = state == SHIFT_IR ? ir_shift_q[0] :
                       state == SHIFT_DR ? (bsr_sel ? bsr_tdo : id_sel ? id_q[0] : byp_q) : 1'b0;
   assign shift_dr   = bsr_sel && state == SHIFT_DR;
   assign capture_dr = bsr_sel && state == CAP_DR;
   assign update_dr  = bsr_sel && state == UPD_DR;
   assign test       = ir_q == IR_EXTEST;
   assign ir_out     = ir_q;
   assign tap_state  = state;
endmodule

// File: tb/tb_tap_ctrl.sv
// tb_tap_ctrl: scoreboard bench for tap_ctrl; stimulus queues expectations, a negedge monitor checks them.
module tb_tap_ctrl;
   logic       clock = 1'b0, reset_l = 1'b0, tms = 1'b1, tdi = 1'b0, bsr_tdo = 1'b0;
   logic       tdo, tdo_en, shift_dr, capture_dr, update_dr, test;
   logic [3:0] ir_out, tap_state;
   int         checks = 0, failures = 0;
   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } chk_t;
   chk_t chk_q[$];
   bit   tdo_q[$];
   always #5 clock = ~clock;
   tap_ctrl #(.IR_WIDTH(4), .IDCODE_VAL(32'h1876_5001)) dut (
      .clock      (clock),
      .reset_l    (reset_l),
      .tms        (tms),
      .tdi        (tdi),
      .bsr_tdo    (bsr_tdo),
      .tdo        (tdo),
      .tdo_en     (tdo_en),
      .shift_dr   (shift_dr),
      .capture_dr (capture_dr),
      .update_dr  (update_dr),
      .test       (test),
      .ir_out     (ir_out),
      .tap_state  (tap_state)
   );
   // sel 0 state, 1 ir_out, 2 controls {tdo_en,shift_dr,capture_dr,update_dr,test,tdo}, 3 pending tdo count
   function automatic logic [31:0] observe(input int sel);
      if (sel == 0) return {28'd0, tap_state};
      if (sel == 1) return {28'd0, ir_out};
      if (sel == 2) return {26'd0, tdo_en, shift_dr, capture_dr, update_dr, test, tdo};
      return 32'(tdo_q.size());
   endfunction
   initial begin
      chk_t        c;
      bit          e;
      logic [31:0] got;
      forever begin
         @(negedge clock);
         while (chk_q.size() > 0) begin
            c   = chk_q.pop_front();
            got = observe(c.sel);
            checks++;
            if (got !== c.exp) begin
               failures++;
               $display("FAIL %s: got %0h expected %0h", c.name, got, c.exp);
            end
         end
         if (tdo_en) begin
            checks++;
            if (tdo_q.size() == 0) begin
               failures++;
               $display("FAIL tdo_unexpected: got tdo_en=1 tdo=%b expected no shift cycle", tdo);
            end else begin
               e = tdo_q.pop_front();
               if (tdo !== e) begin
                  failures++;
                  $display("FAIL tdo_bit: got %b expected %b (state %h)", tdo, e, tap_state);
               end
            end
         end
      end
   end
   task automatic tick(input logic m, input logic d = 1'b0);
      tms = m;
      tdi = d;
      @(posedge clock);
      #1;
   endtask
   task automatic expect_v(input string n, input int s, input logic [31:0] e);
      chk_q.push_back('{n, s, e});
   endtask
   task automatic shift(input int n, input logic [31:0] din, input logic [31:0] dout);
      for (int i = 0; i < n; i++) begin
         tdo_q.push_back(dout[i]);
         tick(i == n - 1, din[i]);
      end
   endtask
   task automatic to_shift_ir();
      tick(1); tick(1); tick(0); tick(0);
   endtask
   initial begin
      logic [3:0] bsr_pat;
      bsr_pat = 4'b1001;
      @(posedge clock);
      #1;
      expect_v("reset_state", 0, 32'hF);
      expect_v("reset_ir", 1, 32'h2);
      expect_v("reset_ctrl", 2, 32'h0);
      reset_l = 1'b1;
      tick(1);
      tick(0);
      to_shift_ir();
      expect_v("shift_ir_state", 0, 32'hA);
      shift(4, 32'h0, 32'h1);
      expect_v("exit1_ir_state", 0, 32'h9);
      expect_v("ir_held_in_scan", 1, 32'h2);
      tick(1);
      expect_v("upd_ir_state", 0, 32'hD);
      expect_v("ir_held_in_upd", 1, 32'h2);
      tick(0);
      expect_v("ir_extest", 1, 32'h0);
      expect_v("test_rises", 2, 32'b000010);
      tick(1);
      tick(0);
      expect_v("extest_capture", 2, 32'b001010);
      tick(0);
      for (int i = 0; i < 4; i++) begin
         bsr_tdo = bsr_pat[i];
         tdo_q.push_back(bsr_pat[i]);
         expect_v("extest_shift_ctrl", 2, {26'd0, 5'b11001, bsr_pat[i]});
         tick(i == 3, 1'b0);
      end
      bsr_tdo = 1'b0;
      expect_v("extest_exit1_ctrl", 2, 32'b000010);
      tick(1);
      expect_v("extest_update", 2, 32'b000110);
      tick(0);
      expect_v("extest_rti_ctrl", 2, 32'b000010);
      to_shift_ir();
      shift(4, 32'h1, 32'h1);
      tick(1);
      expect_v("test_held_until_upd", 2, 32'b000010);
      tick(0);
      expect_v("ir_sample", 1, 32'h1);
      expect_v("test_falls", 2, 32'h0);
      tick(1);
      tick(0);
      expect_v("sample_capture", 2, 32'b001000);
      tick(1);
      tick(1);
      expect_v("sample_update", 2, 32'b000100);
      tick(0);
      to_shift_ir();
      shift(2, 32'h3, 32'h1);
      tick(0);
      tick(0);
      expect_v("pause_ir_state", 0, 32'hB);
      tick(1);
      tick(0);
      shift(2, 32'h3, 32'h0);
      tick(1);
      tick(0);
      expect_v("ir_bypass", 1, 32'hF);
      tick(1);
      tick(0);
      expect_v("bypass_no_capture", 2, 32'h0);
      tick(0);
      expect_v("bypass_shift_ctrl", 2, 32'b100000);
      shift(4, 32'hD, 32'hA);
      tick(1);
      expect_v("bypass_no_update", 2, 32'h0);
      tick(0);
      to_shift_ir();
      tdo_q.push_back(1'b1);
      tick(0, 1'b0);
      tdo_q.push_back(1'b0);
      tick(0, 1'b0);
      reset_l = 1'b0;
      expect_v("midshift_reset_state", 0, 32'hF);
      expect_v("midshift_reset_ir", 1, 32'h2);
      expect_v("midshift_reset_ctrl", 2, 32'h0);
      tick(1);
      reset_l = 1'b1;
      tick(1);
      expect_v("post_reset_ir", 1, 32'h2);
      tick(0);
      tick(1);
      tick(0);
      tick(0);
      tdo_q.push_back(1'b1);
      tick(1);
      tick(1);
      tick(1);
      tick(1);
      expect_v("tms4_not_tlr", 0, 32'h4);
      tick(1);
      expect_v("tms5_tlr", 0, 32'hF);
      tick(0);
      tick(1);
      tick(0);
      expect_v("idcode_no_capture_dr", 2, 32'h0);
      tick(0);
      shift(32, 32'hA5A5_0F0F, 32'h1876_5001);
      expect_v("idcode_exit1_state", 0, 32'h1);
      tick(1);
      tick(0);
      expect_v("tdo_queue_drained", 3, 32'h0);
      @(negedge clock);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/tap_ctrl.md
Name: tap_ctrl

Overview:
JTAG-style test access port controller that drives the boundary-scan register chain. It decodes TMS into the 16-state TAP state machine and holds the instruction register, bypass register and ID register. It produces the chain's shift/capture/update/test controls and muxes the selected register onto TDO. The scan_out of the last chain cell returns on bsr_tdo.

Parameters:
IR_WIDTH, 4, instruction register width (>=2)
IDCODE_VAL, 32'h1876_5001, device ID value; bit 0 forced to 1 on capture regardless of value

Ports:
clock  input  1  test clock; all state changes on rising edge
reset_l  input  1  asynchronous active-low reset
tms  input  1  test mode select, sampled on rising edge
tdi  input  1  test data in, sampled on rising edge in SHIFT_IR/SHIFT_DR
bsr_tdo  input  1  serial return from last boundary-scan cell
tdo  output  1  serial data out
tdo_en  output  1  high while state is SHIFT_IR or SHIFT_DR
shift_dr  output  1  to chain shift input; high in SHIFT_DR when BSR selected
capture_dr  output  1  high in CAPTURE_DR when BSR selected
update_dr  output  1  to chain update clock; high for one cycle in UPDATE_DR when BSR selected
test  output  1  chain output-mux select; high while active instruction is EXTEST
ir_out  output  IR_WIDTH  active (updated) instruction
tap_state  output  4  current TAP state encoding

Behaviour:
- Reset (reset_l=0, async): state=TEST_LOGIC_RESET, ir_out=IDCODE, ir shift reg=0, bypass=0, id shift reg=0. Outputs: tdo=0, tdo_en=0, shift_dr=0, capture_dr=0, update_dr=0, test=0.
- FSM: standard IEEE 1149.1 16-state graph. Each rising edge moves the state per tms.
  - TLR: tms=0 -> RTI.
  - RTI: tms=1 -> SEL_DR.
  - SEL_DR: tms=1 -> SEL_IR, tms=0 -> CAP_DR.
  - SEL_IR: tms=1 -> TLR, tms=0 -> CAP_IR.
  - CAP_x: tms=0 -> SHIFT_x, tms=1 -> EXIT1_x.
  - SHIFT_x: tms=1 -> EXIT1_x.
  - EXIT1_x: tms=0 -> PAUSE_x, tms=1 -> UPD_x.
  - PAUSE_x: tms=1 -> EXIT2_x.
  - EXIT2_x: tms=0 -> SHIFT_x, tms=1 -> UPD_x.
  - UPD_x: tms=1 -> SEL_DR, tms=0 -> RTI.
  - tms=1 for 5 consecutive edges reaches TLR from any state.
- While in TLR (synchronous): ir_out forced to IDCODE each edge.
- Opcodes: EXTEST=0, SAMPLE=1, IDCODE=2, BYPASS=all ones. Every other opcode behaves as BYPASS.
- IR path:
  - Edge leaving CAP_IR loads the ir shift reg with {0...0,01}.
  - In SHIFT_IR each edge shifts right, tdi into MSB.
  - Edge leaving UPD_IR copies the shift reg to ir_out.
  - ir_out is unchanged through the IR scan until that edge.
- DR select, decoded from ir_out: EXTEST/SAMPLE -> BSR; IDCODE -> ID reg; otherwise -> bypass.
- Capture (edge leaving CAP_DR): ID reg loads IDCODE_VAL with bit 0 = 1; bypass loads 0. The BSR captures itself via capture_dr/shift_dr=0.
- Shift (SHIFT_DR): ID reg shifts right with tdi into bit 31; bypass <= tdi.
- tdo is combinational from the current state and registers:
  - SHIFT_IR: ir shift reg[0].
  - SHIFT_DR: selected register's LSB (bypass bit, id[0] or bsr_tdo).
  - Otherwise 0.
  - One bit is emitted per edge, LSB first.
- Chain controls are decoded from the state register: glitch-free, single-cycle where stated.
  - shift_dr, capture_dr and update_dr are all 0 unless BSR is selected.
  - update_dr's rising edge is the chain update clock edge.
- test follows ir_out: it rises on the edge leaving UPD_IR with EXTEST, and falls on the update to any other instruction or on entry to TLR.
- PAUSE states hold all shift registers.
- Reset mid-shift: immediate return to the reset values above; no partial update of ir_out.

Decomposition:
- Shared package tap_defs:
  - 4-bit state encodings (TLR=4'hF, RTI=4'hC, SEL_DR=4'h7, CAP_DR=4'h6, SHIFT_DR=4'h2, EXIT1_DR=4'h1, PAUSE_DR=4'h3, EXIT2_DR=4'h0, UPD_DR=4'h5, SEL_IR=4'h4, CAP_IR=4'hE, SHIFT_IR=4'hA, EXIT1_IR=4'h9, PAUSE_IR=4'hB, EXIT2_IR=4'h8, UPD_IR=4'hD).
  - Opcode constants.
- Sub-module tap_fsm (clock, reset_l, tms -> tap_state) holds the state register and next-state logic.
- tap_ctrl holds the registers, decode and TDO mux.

Test Plan:
- Async reset: assert reset_l=0 mid-cycle -> tap_state=4'hF and ir_out=4'h2 immediately; all control outputs 0.
- From SHIFT_DR, tms=1 for 5 edges -> tap_state=4'hF. After 4 edges it is not yet TLR.
- IR scan of 4'b0000 via tms 0,1,1,0,0 then 4 tdi bits (tms=1 on last) then tms=1,0:
  - tdo during shift reads 1,0,0,0.
  - ir_out=0 and test=1 from the edge leaving UPD_IR.
- IDCODE DR scan after reset (32 shift edges) -> tdo LSB-first equals 32'h1876_5001.
- BYPASS (IR=4'hF): shift tdi pattern 1,0,1,1 -> tdo is 0,1,0,1, a one-edge delay after the captured 0.
- EXTEST with bsr_tdo toggled by the bench:
  - shift_dr=1 only in SHIFT_DR; capture_dr for 1 cycle; update_dr for 1 cycle.
  - tdo mirrors bsr_tdo.
  - Reissuing SAMPLE drops test to 0.
